// File: rtl/sa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sa_pkg                                                               |
// | Shared types and requantization helper for the drain stage.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int unsigned c_max_rows = 256;
    localparam int unsigned c_row_w    = $clog2(c_max_rows + 1);

    function automatic int unsigned row_cnt_w(input int unsigned max_rows);
        return $clog2(max_rows + 1);
    endfunction

    // Returns {saturated, clamped value sign-extended to 32 bits}.
    function automatic logic [32:0] requant(
        input logic signed [31:0] x,
        input logic [7:0]         shift,
        input int unsigned        ow
    );
        logic signed [31:0] y;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        y  = x >>> shift;
        hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (y > hi)
            return {1'b1, hi};
        else if (y < lo)
            return {1'b1, lo};
        return {1'b0, y};
    endfunction

endpackage
`default_nettype wire

// File: rtl/col_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | col_fifo                                                             |
// | Per-column first-word fall-through FIFO with registered storage.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module col_fifo #(
    parameter int w     = 19,
    parameter int depth = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push,
    input  logic         pop,
    input  logic [w-1:0] din,
    output logic [w-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int c_aw = $clog2(depth);

    logic [c_aw:0]  r_wptr;
    logic [c_aw:0]  r_rptr;
    logic [w-1:0]   r_mem [depth];
    logic           w_rd;
    logic           w_wr;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                   (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_rd  = pop && !empty;
    // A pop frees the head slot this cycle, so a full FIFO can still accept.
    assign w_wr  = push && (!full || w_rd);
    assign dout  = r_mem[r_rptr[c_aw-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_rd)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr)
            r_mem[r_wptr[c_aw-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/mac_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_drain                                                            |
// | Re-aligns skewed PE columns into requantized rows, counts per frame. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mac_drain
    import sa_pkg::*;
#(
    parameter int array_width = 8,
    parameter int mac_w       = 19,
    parameter int out_w       = 8,
    parameter int fifo_depth  = 8,
    parameter int max_rows    = c_max_rows
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_vi,
    input  logic [$clog2(max_rows+1)-1:0]        rows_i,
    input  logic [$clog2(mac_w)-1:0]             shift_i,
    input  logic [array_width-1:0][mac_w-1:0]    mac_i,
    input  logic [array_width-1:0]               mac_v_i,
    output logic [array_width-1:0][out_w-1:0]    row_o,
    output logic                                 row_v_o,
    input  logic                                 row_ready_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 ovf_o,
    output logic                                 sat_o
);

    localparam int c_cnt_w = row_cnt_w(max_rows);
    localparam int c_sh_w  = $clog2(mac_w);

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [c_cnt_w-1:0]                 r_rows;
    logic [c_cnt_w-1:0]                 r_cnt;
    logic [c_sh_w-1:0]                  r_shift;
    logic                               r_ovf;
    logic                               r_sat;
    logic [array_width-1:0]             w_push;
    logic [array_width-1:0]             w_pop;
    logic [array_width-1:0]             w_full;
    logic [array_width-1:0]             w_empty;
    logic [array_width-1:0]             w_lane_sat;
    logic [array_width-1:0][mac_w-1:0]  w_head;
    logic [array_width-1:0][out_w-1:0]  w_lane;
    logic                               w_fire;
    logic                               w_last;
    logic                               w_drained;
    logic                               w_row_v;
    logic                               w_done;
    logic                               w_busy;
    logic                               w_start;

    assign w_drained = &w_empty;
    assign w_fire    = w_row_v && row_ready_i;
    assign w_last    = (r_cnt == r_rows - 1'b1);

    for (genvar c = 0; c < array_width; c++) begin : g_col
        logic signed [31:0] w_val;
        logic               w_sat;

        assign w_push[c] = (r_state == RUN) && mac_v_i[c];
        // FLUSH empties leftovers column by column; RUN pops all lanes together.
        assign w_pop[c]  = (r_state == FLUSH) ? !w_empty[c] : w_fire;

        col_fifo #(
            .w     (mac_w),
            .depth (fifo_depth)
        ) u_fifo (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .push   (w_push[c]),
            .pop    (w_pop[c]),
            .din    (mac_i[c]),
            .dout   (w_head[c]),
            .full   (w_full[c]),
            .empty  (w_empty[c])
        );

        always_comb begin
            {w_sat, w_val} = requant(32'(signed'(w_head[c])), 8'(r_shift), out_w);
        end

        assign w_lane[c]     = out_w'(w_val);
        assign w_lane_sat[c] = w_sat;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_vi)          w_state_nxt = RUN;
            RUN:     if (w_fire && w_last)  w_state_nxt = FLUSH;
            FLUSH:   if (w_drained)         w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        w_row_v = 1'b0;
        w_done  = 1'b0;
        w_start = 1'b0;
        case (r_state)
            IDLE:  w_start = start_vi;
            RUN: begin
                w_busy  = 1'b1;
                w_row_v = ~|w_empty;
            end
            FLUSH: begin
                w_busy = 1'b1;
                w_done = w_drained;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rows  <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_ovf   <= 1'b0;
            r_sat   <= 1'b0;
        end else if (w_start) begin
            r_rows  <= (rows_i == '0) ? c_cnt_w'(1) : rows_i;
            r_cnt   <= '0;
            r_shift <= shift_i;
            r_ovf   <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            if (w_fire)
                r_cnt <= r_cnt + 1'b1;
            if (|(w_push & w_full & ~w_pop))
                r_ovf <= 1'b1;
            if (w_fire && |w_lane_sat)
                r_sat <= 1'b1;
        end
    end

    assign row_o   = w_row_v ? w_lane : '0;
    assign row_v_o = w_row_v;
    assign busy_o  = w_busy;
    assign done_o  = w_done;
    assign ovf_o   = r_ovf;
    assign sat_o   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_mac_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mac_drain                                                         |
// | Directed self-checking bench for mac_drain.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mac_drain;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              start_vi;
    logic [8:0]        rows_i;
    logic [4:0]        shift_i;
    logic [7:0][18:0]  mac_i;
    logic [7:0]        mac_v_i;
    logic [7:0][7:0]   row_o;
    logic              row_v_o;
    logic              row_ready_i;
    logic              busy_o;
    logic              done_o;
    logic              ovf_o;
    logic              sat_o;

    int n_cmp = 0;
    int n_err = 0;

    mac_drain u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_vi    (start_vi),
        .rows_i      (rows_i),
        .shift_i     (shift_i),
        .mac_i       (mac_i),
        .mac_v_i     (mac_v_i),
        .row_o       (row_o),
        .row_v_o     (row_v_o),
        .row_ready_i (row_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ovf_o       (ovf_o),
        .sat_o       (sat_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mac_v_i = '0;
        mac_i   = '0;
    endtask

    task automatic start_frame(input int rows, input int sh);
        start_vi = 1'b1;
        rows_i   = 9'(rows);
        shift_i  = 5'(sh);
        tick();
        start_vi = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_vi = 1'b0; row_ready_i = 1'b1;
        rows_i = '0; shift_i = '0;
        idle_inputs();
        tick(); tick();
        n_cmp++; if (row_v_o !== 1'b0) begin n_err++; $display("FAIL reset_row_v: got %b expected 0", row_v_o); end
        n_cmp++; if (row_o !== '0)     begin n_err++; $display("FAIL reset_row: got %h expected 0", row_o); end
        n_cmp++; if (busy_o !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b expected 0", done_o); end
        n_cmp++; if (ovf_o !== 1'b0)   begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf_o); end
        n_cmp++; if (sat_o !== 1'b0)   begin n_err++; $display("FAIL reset_sat: got %b expected 0", sat_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_aligned();
        logic [7:0][7:0] exp;
        start_frame(4, 0);
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL aligned_busy: got %b expected 1", busy_o); end
        for (int k = 0; k < 4; k++) begin
            mac_v_i = 8'hFF;
            for (int c = 0; c < 8; c++) begin
                mac_i[c] = 19'(8 * k + c + 1);
                exp[c]   = 8'(8 * k + c + 1);
            end
            tick();
            n_cmp++; if (row_v_o !== 1'b1) begin n_err++; $display("FAIL aligned_v%0d: got %b expected 1", k, row_v_o); end
            n_cmp++; if (row_o !== exp) begin n_err++; $display("FAIL aligned_row%0d: got %h expected %h", k, row_o, exp); end
        end
        idle_inputs();
        tick();
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL aligned_done: got %b expected 1", done_o); end
        n_cmp++; if (row_v_o !== 1'b0) begin n_err++; $display("FAIL aligned_flush_v: got %b expected 0", row_v_o); end
        tick();
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL aligned_done_once: got %b expected 0", done_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL aligned_idle: got %b expected 0", busy_o); end
        n_cmp++; if (sat_o !== 1'b0) begin n_err++; $display("FAIL aligned_sat: got %b expected 0", sat_o); end
    endtask

    task automatic test_skew();
        logic [7:0][7:0] exp;
        logic            exp_v;
        start_frame(3, 0);
        for (int t = 0; t < 10; t++) begin
            for (int c = 0; c < 8; c++) begin
                if (t - c >= 0 && t - c < 3) begin
                    mac_v_i[c] = 1'b1;
                    mac_i[c]   = 19'(16 * (t - c) + c);
                end else begin
                    mac_v_i[c] = 1'b0;
                end
                exp[c] = 8'(16 * (t - 7) + c);
            end
            tick();
            exp_v = (t >= 7);
            n_cmp++; if (row_v_o !== exp_v) begin n_err++; $display("FAIL skew_v_t%0d: got %b expected %b", t, row_v_o, exp_v); end
            if (exp_v) begin
                n_cmp++; if (row_o !== exp) begin n_err++; $display("FAIL skew_row_t%0d: got %h expected %h", t, row_o, exp); end
            end
        end
        idle_inputs();
        tick();
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL skew_done: got %b expected 1", done_o); end
        tick();
    endtask

    task automatic test_requant();
        logic [7:0][7:0] exp;
        int vals [8] = '{-5, 254, 256, -256, -258, 0, 7, -1};
        logic [7:0] qv [8] = '{8'hFD, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h00, 8'h03, 8'hFF};
        start_frame(2, 2);
        mac_v_i = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            mac_i[c] = (c % 2 == 0) ? 19'(1000) : 19'(-1000);
            exp[c]   = (c % 2 == 0) ? 8'h7F : 8'h80;
        end
        tick();
        n_cmp++; if (row_o !== exp) begin n_err++; $display("FAIL requant_clamp: got %h expected %h", row_o, exp); end
        for (int c = 0; c < 8; c++) begin
            mac_i[c] = 19'(4);
            exp[c]   = 8'h01;
        end
        tick();
        n_cmp++; if (row_o !== exp) begin n_err++; $display("FAIL requant_shift2: got %h expected %h", row_o, exp); end
        n_cmp++; if (sat_o !== 1'b1) begin n_err++; $display("FAIL requant_sat_set: got %b expected 1", sat_o); end
        idle_inputs();
        tick();
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL requant_done: got %b expected 1", done_o); end
        tick();
        start_frame(1, 1);
        n_cmp++; if (sat_o !== 1'b0) begin n_err++; $display("FAIL requant_sat_clear: got %b expected 0", sat_o); end
        mac_v_i = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            mac_i[c] = 19'(vals[c]);
            exp[c]   = qv[c];
        end
        tick();
        n_cmp++; if (row_o !== exp) begin n_err++; $display("FAIL requant_bounds: got %h expected %h", row_o, exp); end
        idle_inputs();
        tick();
        n_cmp++; if (sat_o !== 1'b1) begin n_err++; $display("FAIL requant_sat_edge: got %b expected 1", sat_o); end
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL requant_done2: got %b expected 1", done_o); end
        tick();
    endtask

    task automatic test_stall_ovf();
        logic [7:0][7:0] exp;
        int waits;
        start_frame(2, 0);
        row_ready_i = 1'b0;
        exp[0] = 8'd10;
        for (int c = 1; c < 8; c++) exp[c] = 8'(100 + c);
        for (int i = 0; i < 9; i++) begin
            mac_v_i  = (i == 0) ? 8'hFF : 8'h01;
            mac_i[0] = 19'(10 + i);
            for (int c = 1; c < 8; c++) mac_i[c] = 19'(100 + c);
            tick();
            n_cmp++; if (row_o !== exp) begin n_err++; $display("FAIL stall_row_i%0d: got %h expected %h", i, row_o, exp); end
            if (i == 7) begin
                n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL stall_ovf_early: got %b expected 0", ovf_o); end
            end
        end
        n_cmp++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL stall_ovf: got %b expected 1", ovf_o); end
        idle_inputs();
        tick();
        n_cmp++; if (row_v_o !== 1'b1) begin n_err++; $display("FAIL stall_hold_v: got %b expected 1", row_v_o); end
        row_ready_i = 1'b1;
        tick();
        n_cmp++; if (row_v_o !== 1'b0) begin n_err++; $display("FAIL stall_after_pop: got %b expected 0", row_v_o); end
        mac_v_i = 8'hFE;
        for (int c = 1; c < 8; c++) mac_i[c] = 19'(200 + c);
        tick();
        n_cmp++; if (row_o[0] !== 8'd11) begin n_err++; $display("FAIL stall_lane0: got %h expected 0b", row_o[0]); end
        idle_inputs();
        tick();
        waits = 0;
        while (!done_o && waits < 20) begin
            tick();
            waits++;
        end
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL stall_done_timeout: got %b expected 1", done_o); end
        n_cmp++; if (waits != 6) begin n_err++; $display("FAIL stall_flush_len: got %0d expected 6", waits); end
        tick();
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL stall_idle: got %b expected 0", busy_o); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0][7:0] exp;
        start_frame(5, 0);
        mac_v_i = 8'hFF;
        for (int c = 0; c < 8; c++) mac_i[c] = 19'(c + 1);
        tick();
        tick();
        mac_v_i  = 8'h01;
        mac_i[0] = 19'(77);
        tick();
        rst_ni = 1'b0;
        idle_inputs();
        tick();
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b expected 0", done_o); end
        n_cmp++; if (row_v_o !== 1'b0) begin n_err++; $display("FAIL midrst_row_v: got %b expected 0", row_v_o); end
        rst_ni = 1'b1;
        tick();
        start_frame(1, 0);
        mac_v_i = 8'hFE;
        for (int c = 0; c < 8; c++) begin
            mac_i[c] = 19'(50 + c);
            exp[c]   = 8'(50 + c);
        end
        tick();
        n_cmp++; if (row_v_o !== 1'b0) begin n_err++; $display("FAIL midrst_fifo_empty: got %b expected 0", row_v_o); end
        mac_v_i = 8'h01;
        tick();
        n_cmp++; if (row_o !== exp) begin n_err++; $display("FAIL midrst_row: got %h expected %h", row_o, exp); end
        idle_inputs();
        tick();
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL midrst_done2: got %b expected 1", done_o); end
        tick();
    endtask

    task automatic test_start_ignored();
        logic [7:0][7:0] exp;
        start_frame(2, 0);
        mac_v_i = 8'hFF;
        for (int c = 0; c < 8; c++) mac_i[c] = 19'(20 + c);
        tick();
        start_vi = 1'b1;
        rows_i   = 9'd5;
        shift_i  = 5'd3;
        for (int c = 0; c < 8; c++) begin
            mac_i[c] = 19'(40 + c);
            exp[c]   = 8'(40 + c);
        end
        tick();
        start_vi = 1'b0;
        n_cmp++; if (row_o !== exp) begin n_err++; $display("FAIL ign_row: got %h expected %h", row_o, exp); end
        idle_inputs();
        tick();
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL ign_done: got %b expected 1", done_o); end
        tick();
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL ign_idle: got %b expected 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_skew();
        test_requant();
        test_stall_ovf();
        test_reset_midframe();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mac_drain.md
# mac_drain

Downstream stage of the PE array. Each PE column delivers its `mac_w`-bit results on its own valid strobe, and the columns are skewed in time relative to each other. `mac_drain` buffers each column in a private FIFO and re-aligns the columns into full output rows. It requantizes each lane (arithmetic right shift, then saturation to `out_w`) and hands rows to the result writer over a valid/ready handshake. It also counts rows per frame and raises `done_o` when the frame is complete.

## Interface
- `array_width`, 8, number of PE columns / output lanes
- `mac_w`, 19, signed accumulator width per column
- `out_w`, 8, signed output lane width after requantization
- `fifo_depth`, 8, entries per column FIFO (power of two, ≥2)
- `max_rows`, 256, upper bound on rows per frame; sets the row-counter width to `$clog2(max_rows+1)`

- `clk_i` in 1 — single clock; all logic rising-edge
- `rst_ni` in 1 — reset; synchronous, active-low
- `start_vi` in 1 — one-cycle pulse; begins a frame, latches `rows_i` and `shift_i`
- `rows_i` in `$clog2(max_rows+1)` — rows expected in this frame (1..`max_rows`)
- `shift_i` in `$clog2(mac_w)` — arithmetic right-shift amount
- `mac_i` in `[array_width-1:0][mac_w-1:0]` — per-column MAC results from the PE array
- `mac_v_i` in `[array_width]` — per-column valid
- `row_o` out `[array_width-1:0][out_w-1:0]` — aligned, requantized row
- `row_v_o` out 1 — row valid
- `row_ready_i` in 1 — consumer ready
- `busy_o` out 1 — frame in progress
- `done_o` out 1 — one-cycle pulse after the last row handshakes
- `ovf_o` out 1 — sticky; a valid arrived into a full column FIFO
- `sat_o` out 1 — sticky; any lane saturated during this frame

## Operation
- FSM states: `IDLE`, `RUN`, `FLUSH`.
  - `IDLE` → `RUN` on `start_vi`: latch `rows_i` and `shift_i`, clear the row counter, `sat_o` and `ovf_o`.
  - `RUN` → `FLUSH` once the last expected row has handshaked.
  - `FLUSH` drains any residual FIFO entries (drop, no output), pulses `done_o` in its final cycle, then → `IDLE`.
- `start_vi` outside `IDLE` is ignored.
- `rows_i == 0` is treated as 1.
- **Column FIFO behaviour**
  - In `RUN`, each `mac_v_i[c]` pushes `mac_i[c]` into FIFO c.
  - Valids arriving in `IDLE` or `FLUSH` are dropped.
  - Push into a full FIFO: data is dropped and `ovf_o` is set; other columns are unaffected.
  - A push and a pop on the same FIFO in the same cycle are both honoured, including when the FIFO is full.
- **Row formation:** `row_v_o` = `RUN` and all FIFOs non-empty. A handshake (`row_v_o && row_ready_i`) pops every FIFO at once and increments the row counter.
- **Requantization, per lane:**
  - `y = x >>> shift` (signed).
  - If `y > 2^(out_w-1)-1`, clamp to the maximum; if `y < -2^(out_w-1)`, clamp to the minimum; either clamp sets `sat_o`.
  - The logic is combinational from the FIFO heads.
- **Stall rule:** `row_o` is stable while `row_v_o && !row_ready_i`.
- **Reset:** in-frame reset discards all FIFO contents and returns the FSM to `IDLE`; no `done_o` is produced.

## Timing
- Reset values: `row_v_o`=0, `row_o`=0, `busy_o`=0, `done_o`=0, `ovf_o`=0, `sat_o`=0, all FIFOs empty, FSM in `IDLE`.
- `busy_o` is 1 in `RUN` and `FLUSH`, and rises the cycle after `start_vi`.
- Latency: the cycle after the last column of a row is pushed, `row_v_o`=1 (first-word fall-through from registered FIFO storage).
- Throughput: one row per cycle when the columns arrive aligned and `row_ready_i`=1.
- `done_o` is asserted exactly one cycle, at least one cycle after the final handshake. `IDLE` is re-entered the next cycle, so a new `start_vi` can be accepted immediately.
- FIFO pointers wrap modulo `fifo_depth`. Full and empty are distinguished by an extra pointer bit.

## Structure
- Package `sa_pkg`: the FSM state enum, a saturate/shift function `requant(x, shift)`, and a `clog2`-derived width localparam for the row counter.
- Sub-module `col_fifo` (params `w`, `depth`; ports: push/pop/data, `full`, `empty`), instantiated `array_width` times in a generate loop.
- The top module holds the FSM, row counter, requant lanes and sticky flags.

## Test plan
- Aligned columns, `rows_i`=4, `shift_i`=0, values 1..32, ready=1 → 4 rows on consecutive cycles, lane values 1..32 in order; `done_o` pulses once; `sat_o`=0.
- Column c delayed by c cycles (skew 0..7), `rows_i`=3 → each `row_v_o` appears the cycle after column 7 pushes; rows are correctly aligned.
- `mac_i`=+1000 / −1000, `shift_i`=2, `out_w`=8 → lanes 127 / −128; `sat_o`=1. `mac_i`=−5, `shift_i`=1 → −3.
- `row_ready_i`=0 for 10 cycles with 9 pushes into column 0 → `ovf_o`=1, the 9th value is lost; `row_o` is held stable through the stall.
- Reset asserted mid-frame after 2 of 5 rows → next cycle `busy_o`=0, FIFOs empty, no `done_o`. A fresh frame with `rows_i`=1 completes normally.
- `start_vi` pulsed during `RUN` → ignored; the row count and `done_o` timing are unchanged.
